// File: rtl/coin_start_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : coin_start_sequencer
// Description : Turns a player start press into a frame-timed arcade
//               sequence (coin pulse, gap, start pulse, hold-off). All phase
//               lengths are counted in vblank rising edges. A direct coin
//               button is ORed onto the coin output with one cycle of delay.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_start_sequencer #(
  parameter int COIN_FRAMES    = 4,
  parameter int GAP_FRAMES     = 8,
  parameter int START_FRAMES   = 4,
  parameter int HOLDOFF_FRAMES = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic vblank,
  input  logic btn_start1,
  input  logic btn_start2,
  input  logic btn_coin,
  output logic coin,
  output logic start1,
  output logic start2,
  output logic busy
);

  // Phase lengths must fit the 8-bit frame counter and be non-zero.
  generate
    if (COIN_FRAMES < 1 || COIN_FRAMES > 255 ||
        GAP_FRAMES < 1 || GAP_FRAMES > 255 ||
        START_FRAMES < 1 || START_FRAMES > 255 ||
        HOLDOFF_FRAMES < 1 || HOLDOFF_FRAMES > 255) begin : g_bad_params
      $error("coin_start_sequencer: phase frame counts must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] COIN_LEN    = 8'(COIN_FRAMES);
  localparam logic [7:0] GAP_LEN     = 8'(GAP_FRAMES);
  localparam logic [7:0] START_LEN   = 8'(START_FRAMES);
  localparam logic [7:0] HOLDOFF_LEN = 8'(HOLDOFF_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COIN    = 3'd1,
    ST_GAP     = 3'd2,
    ST_START   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [7:0] frame_cnt, frame_cnt_next;
  logic       sel, sel_next;
  logic       vblank_prev, start1_prev, start2_prev;
  logic       frame_tick, req1, req2, phase_done;

  assign frame_tick = vblank & ~vblank_prev;
  assign req1       = btn_start1 & ~start1_prev;
  assign req2       = btn_start2 & ~start2_prev;
  // A phase ends on the tick that would take the counter from 1 to 0.
  assign phase_done = frame_tick && (frame_cnt == 8'd1);

  // Previous-value registers for edge detection of vblank and start buttons.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vblank_prev <= 1'b0;
      start1_prev <= 1'b0;
      start2_prev <= 1'b0;
    end else begin
      vblank_prev <= vblank;
      start1_prev <= btn_start1;
      start2_prev <= btn_start2;
    end
  end

  // FSM state, frame counter, player select and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame_cnt <= 8'd0;
      sel       <= 1'b0;
      coin      <= 1'b0;
      start1    <= 1'b0;
      start2    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      sel       <= sel_next;
      coin      <= (state_next == ST_COIN) | btn_coin;
      start1    <= (state_next == ST_START) & ~sel_next;
      start2    <= (state_next == ST_START) & sel_next;
      busy      <= (state_next != ST_IDLE);
    end
  end

  // Next-state logic; each state entry reloads the counter with its length.
  always_comb begin
    state_next     = state;
    sel_next       = sel;
    frame_cnt_next = frame_cnt;
    if (frame_tick && frame_cnt != 8'd0) begin
      frame_cnt_next = frame_cnt - 8'd1;
    end
    case (state)
      ST_IDLE: begin
        // start1 has priority over a simultaneous start2 edge
        if (req1) begin
          sel_next       = 1'b0;
          state_next     = ST_COIN;
          frame_cnt_next = COIN_LEN;
        end else if (req2) begin
          sel_next       = 1'b1;
          state_next     = ST_COIN;
          frame_cnt_next = COIN_LEN;
        end
      end
      ST_COIN: begin
        if (phase_done) begin
          state_next     = ST_GAP;
          frame_cnt_next = GAP_LEN;
        end
      end
      ST_GAP: begin
        if (phase_done) begin
          state_next     = ST_START;
          frame_cnt_next = START_LEN;
        end
      end
      ST_START: begin
        if (phase_done) begin
          state_next     = ST_HOLDOFF;
          frame_cnt_next = HOLDOFF_LEN;
        end
      end
      ST_HOLDOFF: begin
        if (phase_done) begin
          state_next     = ST_IDLE;
          frame_cnt_next = 8'd0;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        frame_cnt_next = 8'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_start_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_coin_start_sequencer
// Description : Directed scoreboard bench. Stimulus pushes expected output
//               transitions (cycle, signal, value) into an ordered queue; a
//               monitor pops one entry per observed output transition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_start_sequencer;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic vblank = 1'b0;
  logic btn_start1 = 1'b0;
  logic btn_start2 = 1'b0;
  logic btn_coin = 1'b0;
  logic coin, start1, start2, busy;

  coin_start_sequencer dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vblank    (vblank),
    .btn_start1(btn_start1),
    .btn_start2(btn_start2),
    .btn_coin  (btn_coin),
    .coin      (coin),
    .start1    (start1),
    .start2    (start2),
    .busy      (busy)
  );

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } ev_t;

  ev_t   exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    e0, e1, e2, e3, e4;
  string names[4] = '{"coin", "start1", "start2", "busy"};

  initial forever #5 clk_sys = ~clk_sys;

  // Cycle counter and frame timing: vblank high for the first 10 cycles of every 100.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      cyc    = cyc + 1;
      vblank = ((cyc % 100) < 10);
    end
  end

  // Nth frame-tick clock edge strictly after clock edge edge_n.
  function automatic int tick_after(input int edge_n, input int n);
    return (((edge_n - 1) / 100) + 1) * 100 + 1 + (n - 1) * 100;
  endfunction

  function automatic void push_ev(input int c, input int s, input logic v);
    ev_t ev;
    int  i;
    ev.cyc = c;
    ev.sig = s;
    ev.val = v;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].sig <= s)))
      i++;
    exp_q.insert(i, ev);
  endfunction

  // Expected transitions for a request first driven in cycle k; n_ev limits how many are queued.
  task automatic push_seq(input int k, input bit p2, input int n_ev);
    int ss;
    ss = p2 ? 2 : 1;
    e0 = k + 1;
    e1 = tick_after(e0, 4);
    e2 = tick_after(e1, 8);
    e3 = tick_after(e2, 4);
    e4 = tick_after(e3, 16);
    push_ev(e0, 0, 1'b1);
    push_ev(e0, 3, 1'b1);
    if (n_ev > 1) push_ev(e1, 0, 1'b0);
    if (n_ev > 2) push_ev(e2, ss, 1'b1);
    if (n_ev > 3) push_ev(e3, ss, 1'b0);
    if (n_ev > 4) push_ev(e4, 3, 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: {busy,start2,start1,coin} actual=%b required=%b cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Wait for all expected transitions to be observed, then hold quiet for a while.
  task automatic drain(input string nm, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk_sys);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: pending events actual=%0d required=0 (next cyc=%0d sig=%s)",
               nm, exp_q.size(), exp_q[0].cyc, names[exp_q[0].sig]);
      exp_q.delete();
    end
    step(300);
  endtask

  // Monitor: every output transition must match the head of the expected queue.
  initial begin
    logic [3:0] prev;
    logic [3:0] cur;
    ev_t        ev;
    prev = 4'b0000;
    forever begin
      @(negedge clk_sys);
      cur = {busy, start2, start1, coin};
      for (int i = 0; i < 4; i++) begin
        if (cur[i] !== prev[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: actual=%b at cyc=%0d required=no transition",
                     names[i], cur[i], cyc);
          end else begin
            ev = exp_q.pop_front();
            if (ev.cyc != cyc || ev.sig != i || ev.val !== cur[i]) begin
              failures++;
              $display("FAIL event: actual %s=%b at cyc=%0d required %s=%b at cyc=%0d",
                       names[i], cur[i], cyc, names[ev.sig], ev.val, ev.cyc);
            end
          end
        end
      end
      prev = cur;
    end
  end

  // Watchdog: the run must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int k;
    int c;

    // Reset state
    step(3);
    chk("reset_outputs", {busy, start2, start1, coin}, 4'b0000);
    wait_cyc(20);
    reset = 1'b0;
    step(5);
    chk("idle_after_release", {busy, start2, start1, coin}, 4'b0000);

    // 1: start1 pulse of 3 cycles -> full player-1 sequence
    wait_cyc(40);
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(3);
    btn_start1 = 1'b0;
    drain("t1_start1", 4000);

    // 2: simultaneous start1/start2 edges -> start1 wins, one coin pulse
    k = cyc;
    btn_start1 = 1'b1;
    btn_start2 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(3);
    btn_start1 = 1'b0;
    btn_start2 = 1'b0;
    drain("t2_simultaneous", 4000);

    // 3: start2 presses in every busy phase ignored; press after busy falls runs player 2
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(2);
    btn_start1 = 1'b0;
    c = e4;
    foreach (names[i]) begin
      if (i == 0) wait_cyc(e0 + 10);
      if (i == 1) wait_cyc(e1 + 10);
      if (i == 2) wait_cyc(e2 + 10);
      if (i == 3) wait_cyc(e3 + 10);
      btn_start2 = 1'b1;
      step(2);
      btn_start2 = 1'b0;
    end
    wait_cyc(c + 1);
    k = cyc;
    btn_start2 = 1'b1;
    push_seq(k, 1'b1, 5);
    step(2);
    btn_start2 = 1'b0;
    drain("t3_busy_ignore", 8000);

    // 4: start1 held for 200 frames -> exactly one sequence
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(20000);
    btn_start1 = 1'b0;
    drain("t4_hold", 4000);

    // 5: direct coin in IDLE and during START, one cycle late, FSM timing untouched
    k = cyc;
    btn_coin = 1'b1;
    push_ev(k + 1, 0, 1'b1);
    push_ev(k + 6, 0, 1'b0);
    step(5);
    btn_coin = 1'b0;
    drain("t5_coin_idle", 100);
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(2);
    btn_start1 = 1'b0;
    wait_cyc(e2 + 20);
    k = cyc;
    btn_coin = 1'b1;
    push_ev(k + 1, 0, 1'b1);
    push_ev(k + 6, 0, 1'b0);
    step(5);
    btn_coin = 1'b0;
    drain("t5_coin_start", 4000);

    // 6: reset in START with counter at 2 -> outputs clear at once, then a fresh sequence
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 3);
    step(2);
    btn_start1 = 1'b0;
    c = tick_after(e2, 2) + 10;
    wait_cyc(c);
    chk("t6_start_before_reset", {busy, start2, start1, coin}, 4'b1010);
    push_ev(c, 1, 1'b0);
    push_ev(c, 3, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_reset_async", {busy, start2, start1, coin}, 4'b0000);
    wait_cyc(c + 5);
    reset = 1'b0;
    step(3);
    chk("t6_idle_after_reset", {busy, start2, start1, coin}, 4'b0000);
    k = cyc;
    btn_start1 = 1'b1;
    push_seq(k, 1'b0, 5);
    step(2);
    btn_start1 = 1'b0;
    drain("t6_fresh_sequence", 4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
